// File: rtl/fc_in_stager.sv
// fc_in_stager: serial-to-parallel activation stager for the fully-connected layer.
// Collects IN activations from a valid/ready stream into x, then holds x
// steady through a settle window before raising x_valid and waiting for the
// consumer handshake.
module fc_in_stager #(
    parameter int WIDTH  = 8,
    parameter int IN     = 128,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic [WIDTH-1:0] x [0:IN-1],
    output logic             x_valid,
    input  logic             x_ready,
    output logic             err_len
);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam int              CNT_W       = (IN > 1) ? $clog2(IN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(IN - 1);
    localparam logic [7:0]       SETTLE_INIT = 8'(SETTLE);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       settle_q, settle_d;
    logic [WIDTH-1:0] x_q [0:IN-1];
    logic [WIDTH-1:0] x_d [0:IN-1];
    logic             x_valid_q, x_valid_d;
    logic             err_len_q, err_len_d;

    // Ready is a pure decode of registered state so it never loops back through s_valid.
    assign s_ready = (state_q == ST_FILL);
    assign x_valid = x_valid_q;
    assign err_len = err_len_q;
    assign x       = x_q;

    // Next-state logic: fill on accepted beats, count down the settle window, wait for handshake.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        settle_d  = settle_q;
        x_d       = x_q;
        x_valid_d = x_valid_q;
        err_len_d = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (s_valid) begin
                    x_d[cnt_q] = s_data;
                    if (cnt_q == LAST_IDX) begin
                        // Full vector: a missing s_last is flagged but the data is still used.
                        cnt_d     = '0;
                        settle_d  = SETTLE_INIT;
                        state_d   = ST_SETTLE;
                        err_len_d = ~s_last;
                    end else if (s_last) begin
                        // Short vector: restart from index 0, stale entries get overwritten later.
                        cnt_d     = '0;
                        err_len_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_SETTLE: begin
                if (settle_q == 8'd0) begin
                    state_d   = ST_HOLD;
                    x_valid_d = 1'b1;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end

            ST_HOLD: begin
                if (x_valid_q && x_ready) begin
                    state_d   = ST_FILL;
                    x_valid_d = 1'b0;
                end
            end

            default: begin
                state_d   = ST_FILL;
                x_valid_d = 1'b0;
            end
        endcase
    end

    // State, counters and the activation vector; reset clears everything including x.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FILL;
            cnt_q     <= '0;
            settle_q  <= 8'd0;
            x_valid_q <= 1'b0;
            err_len_q <= 1'b0;
            for (int i = 0; i < IN; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            settle_q  <= settle_d;
            x_valid_q <= x_valid_d;
            err_len_q <= err_len_d;
            for (int i = 0; i < IN; i++) begin
                x_q[i] <= x_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fc_in_stager.sv
// Directed bench for fc_in_stager with a scoreboard queue of expected x contents.
module tb_fc_in_stager;

    localparam int WIDTH = 8;
    localparam int IN    = 128;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid, s_valid0, s_last;
    logic [WIDTH-1:0] s_data;
    logic             s_ready, s_ready0;
    logic [WIDTH-1:0] x  [0:IN-1];
    logic [WIDTH-1:0] x0 [0:IN-1];
    logic             x_valid, x_valid0;
    logic             x_ready, x_ready0;
    logic             err_len, err_len0;

    int checks  = 0;
    int errors  = 0;
    int err_cnt = 0;
    int err_cnt0 = 0;

    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] mdl   [0:IN-1];

    always #5 clk = ~clk;

    fc_in_stager #(.WIDTH(WIDTH), .IN(IN), .SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .x(x), .x_valid(x_valid), .x_ready(x_ready), .err_len(err_len)
    );

    fc_in_stager #(.WIDTH(WIDTH), .IN(IN), .SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid0), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready0), .x(x0), .x_valid(x_valid0), .x_ready(x_ready0), .err_len(err_len0)
    );

    // Count err_len pulses away from the active edge.
    always @(negedge clk) begin
        if (err_len)  err_cnt  <= err_cnt + 1;
        if (err_len0) err_cnt0 <= err_cnt0 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input bit which, input logic [WIDTH-1:0] d, input logic last);
        int n = 0;
        s_data = d;
        s_last = last;
        if (which) s_valid0 = 1'b1; else s_valid = 1'b1;
        while (!(which ? s_ready0 : s_ready) && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("beat_ready_timeout", n, 0);
        exp_q.push_back(d);
        step();
        s_valid  = 1'b0;
        s_valid0 = 1'b0;
        s_last   = 1'b0;
    endtask

    task automatic send_vec(input bit which, input int base, input int mult,
                            input bit gap, input logic last_ok);
        for (int i = 0; i < IN; i++) begin
            beat(which, WIDTH'(base + i * mult), (i == IN - 1) ? last_ok : 1'b0);
            if (gap && i < IN - 1) step();
        end
    endtask

    task automatic wait_valid(input bit which, input int exp_lat, input string tag);
        int n = 0;
        while (!(which ? x_valid0 : x_valid) && n < 40) begin
            step();
            n++;
        end
        check(tag, n, exp_lat);
        check({tag, "_xv"}, which ? x_valid0 : x_valid, 1'b1);
    endtask

    task automatic check_vec(input bit which, input string tag);
        check({tag, "_qsize"}, exp_q.size(), IN);
        for (int i = 0; i < IN; i++) begin
            if (exp_q.size() > 0) mdl[i] = exp_q.pop_front();
            else                  mdl[i] = '0;
            check(tag, which ? x0[i] : x[i], mdl[i]);
        end
    endtask

    task automatic handshake(input bit which, input string tag);
        if (which) x_ready0 = 1'b1; else x_ready = 1'b1;
        step();
        x_ready  = 1'b0;
        x_ready0 = 1'b0;
        check({tag, "_xv_drop"}, which ? x_valid0 : x_valid, 1'b0);
        check({tag, "_s_ready"}, which ? s_ready0 : s_ready, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        logic [WIDTH-1:0] acc;
        acc = '0;
        for (int i = 0; i < IN; i++) acc = acc | x[i];
        check(tag, acc, 0);
    endtask

    initial begin
        int eb;
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_valid0 = 1'b0;
        s_last   = 1'b0;
        s_data   = '0;
        x_ready  = 1'b0;
        x_ready0 = 1'b0;

        // Reset values
        #12;
        check("rst_s_ready", s_ready, 1'b1);
        check("rst_x_valid", x_valid, 1'b0);
        check("rst_err_len", err_len, 1'b0);
        check_all_zero("rst_x_zero");
        rst_n = 1'b1;
        step();
        check("post_rst_s_ready", s_ready, 1'b1);

        // Back-to-back stream x[i] = i+1
        send_vec(1'b0, 1, 1, 1'b0, 1'b1);
        check("t1_s_ready_drop", s_ready, 1'b0);
        wait_valid(1'b0, 3, "t1_lat");
        check("t1_err_cnt", err_cnt, 0);
        check("t1_x0", x[0], 8'd1);
        check("t1_x127", x[127], 8'd128);
        check_vec(1'b0, "t1_vec");
        handshake(1'b0, "t1_hs");

        // Gapped stream with distinct data, then long hold
        send_vec(1'b0, 3, 5, 1'b1, 1'b1);
        wait_valid(1'b0, 3, "t2_lat");
        check_vec(1'b0, "t2_vec");
        for (int c = 0; c < 20; c++) begin
            step();
            check("t3_hold_xv", x_valid, 1'b1);
            check("t3_hold_x0", x[0], mdl[0]);
            check("t3_hold_x64", x[64], mdl[64]);
            check("t3_hold_x127", x[127], mdl[127]);
        end
        handshake(1'b0, "t3_hs");

        // x_ready outside HOLD has no effect
        x_ready = 1'b1;
        step();
        step();
        x_ready = 1'b0;
        check("t3_xr_ignored_sr", s_ready, 1'b1);
        check("t3_xr_ignored_xv", x_valid, 1'b0);

        // Next vector fills from x[0]; early s_last on beat 50
        eb = err_cnt;
        beat(1'b0, 8'hAA, 1'b0);
        check("t4_first_x0", x[0], 8'hAA);
        check("t4_first_x1_old", x[1], mdl[1]);
        for (int i = 1; i <= 50; i++) beat(1'b0, WIDTH'(i), (i == 50) ? 1'b1 : 1'b0);
        check("t4_err_pulse", err_len, 1'b1);
        check("t4_s_ready", s_ready, 1'b1);
        step();
        check("t4_err_clear", err_len, 1'b0);
        check("t4_err_cnt", err_cnt, eb + 1);
        step();
        step();
        step();
        check("t4_no_xv", x_valid, 1'b0);
        check("t4_s_ready_still", s_ready, 1'b1);
        exp_q.delete();
        send_vec(1'b0, 200, 255, 1'b0, 1'b1);
        wait_valid(1'b0, 3, "t4_lat");
        check("t4_err_cnt_after", err_cnt, eb + 1);
        check_vec(1'b0, "t4_vec");
        handshake(1'b0, "t4_hs");

        // Missing s_last on beat 127, SETTLE = 2
        eb = err_cnt;
        send_vec(1'b0, 9, 7, 1'b0, 1'b0);
        wait_valid(1'b0, 3, "t5_lat");
        check("t5_err_cnt", err_cnt, eb + 1);
        check_vec(1'b0, "t5_vec");
        handshake(1'b0, "t5_hs");

        // Missing s_last on beat 127, SETTLE = 0
        send_vec(1'b1, 50, 3, 1'b0, 1'b0);
        wait_valid(1'b1, 1, "t5z_lat");
        check("t5z_err_cnt", err_cnt0, 1);
        check_vec(1'b1, "t5z_vec");
        handshake(1'b1, "t5z_hs");

        // Asynchronous reset during SETTLE with err_len high
        send_vec(1'b0, 77, 1, 1'b0, 1'b0);
        check("t6_err_before", err_len, 1'b1);
        check("t6_in_settle", s_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_err", err_len, 1'b0);
        check("t6_rst_xv", x_valid, 1'b0);
        check("t6_rst_sr", s_ready, 1'b1);
        check_all_zero("t6_rst_x_zero");
        exp_q.delete();
        #1 rst_n = 1'b1;
        step();
        check("t6_rel_sr", s_ready, 1'b1);
        check("t6_rel_xv", x_valid, 1'b0);

        // Asynchronous reset during FILL after 64 beats
        for (int i = 0; i < 64; i++) beat(1'b0, WIDTH'(i + 1), 1'b0);
        check("t6_fill_x63", x[63], 8'd64);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("t6_fill_rst_zero");
        check("t6_fill_rst_xv", x_valid, 1'b0);
        check("t6_fill_rst_err", err_len, 1'b0);
        exp_q.delete();
        #1 rst_n = 1'b1;
        step();
        check("t6_fill_rel_sr", s_ready, 1'b1);
        send_vec(1'b0, 31, 1, 1'b0, 1'b1);
        wait_valid(1'b0, 3, "t6_lat");
        check_vec(1'b0, "t6_vec");
        handshake(1'b0, "t6_hs");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
